demux16_pipe: RTL and testbench

//  Registered 1-to-2 demultiplexer for 16-bit CPU datapath words; the inverse of the 16-bit 2:1 mux.
//  - Steers one source word to destination A (sel=0) or destination B (sel=1).
//  - Valid/ready on every side; one-entry output register per destination.
//  - Sits between an ALU/bus source and two consumers, e.g. the register-file write port and the memory store port.

---
 rtl/demux16_pipe_pkg.sv | 13 +
 rtl/demux16_pipe_if.sv | 30 +++
 rtl/demux16_pipe_slot.sv | 54 +++++
 rtl/demux16_pipe.sv | 46 ++++
 tb/tb_demux16_pipe.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/demux16_pipe_pkg.sv
// Shared constants and slot state encoding for the 16-bit registered 1:2 demux.
package demux16_pipe_pkg;
    localparam int   DATA_W  = 16;
    localparam int   CNT_DEF = 8;
    localparam int   NUM_DST = 2;
    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_st_e;
endpackage

// File: rtl/demux16_pipe_if.sv
// Source-side and destination-side handshake bundle for demux16_pipe.
import demux16_pipe_pkg::*;

interface demux16_pipe_if #(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = CNT_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
    );

    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
    );
endinterface

// File: rtl/demux16_pipe_slot.sv
// One-entry destination register with delivered-word counter.
module demux_slot
    import demux16_pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    slot_st_e         state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        drain   = (state_q == ST_FULL) & out_ready;
        // A load on a draining slot refills it in the same edge.
        if (load) begin
            state_d = ST_FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
        if (drain) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign full      = (state_q == ST_FULL);
    assign out_valid = full;
    assign out_data  = data_q;
    assign count     = cnt_q;
endmodule

// File: rtl/demux16_pipe.sv
// Registered 1-to-2 demultiplexer: select decode and source ready over two slots.
module demux16_pipe
    import demux16_pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = CNT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    demux16_pipe_if.slave bus
);
    logic [NUM_DST-1:0]            load, full, ready, valid;
    logic [NUM_DST-1:0][WIDTH-1:0] odata;
    logic [NUM_DST-1:0][CNT_W-1:0] cnt;
    logic                          accept;

    assign ready[SEL_A] = bus.a_ready;
    assign ready[SEL_B] = bus.b_ready;

    // Only the selected slot can stall the source; in_data never feeds in_ready.
    assign bus.in_ready = ~rst & (~full[bus.in_sel] | ready[bus.in_sel]);
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar g = 0; g < NUM_DST; g++) begin : g_slot
        assign load[g] = accept & (bus.in_sel == 1'(g));

        demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (bus.in_data),
            .out_valid (valid[g]),
            .out_ready (ready[g]),
            .out_data  (odata[g]),
            .count     (cnt[g]),
            .full      (full[g])
        );
    end

    assign bus.a_valid = valid[SEL_A];
    assign bus.a_data  = odata[SEL_A];
    assign bus.a_count = cnt[SEL_A];
    assign bus.b_valid = valid[SEL_B];
    assign bus.b_data  = odata[SEL_B];
    assign bus.b_count = cnt[SEL_B];
endmodule

// File: tb/tb_demux16_pipe.sv
// Scoreboard bench: driver pushes expected words on acceptance, monitor pops on delivery.
module tb_demux16_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nfail = 0;
    bit   mon_en = 1'b0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [7:0]  exp_ac = '0;
    logic [7:0]  exp_bc = '0;

    demux16_pipe_if #(.WIDTH(16), .CNT_W(8)) bus ();

    demux16_pipe #(.WIDTH(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, reflecting the handshake taken at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_count", 32'(bus.a_count), 32'(exp_ac));
            chk("b_count", 32'(bus.b_count), 32'(exp_bc));
            if (rst) begin
                qa.delete();
                qb.delete();
                exp_ac = '0;
                exp_bc = '0;
            end else begin
                if (bus.a_valid && bus.a_ready) begin
                    if (qa.size() == 0) chk("a_unexpected", 32'(bus.a_data), 32'hFFFF_FFFF);
                    else chk("a_data", 32'(bus.a_data), 32'(qa.pop_front()));
                    exp_ac++;
                end
                if (bus.b_valid && bus.b_ready) begin
                    if (qb.size() == 0) chk("b_unexpected", 32'(bus.b_data), 32'hFFFF_FFFF);
                    else chk("b_data", 32'(bus.b_data), 32'(qb.pop_front()));
                    exp_bc++;
                end
            end
        end
    end

    // Drive one word; returns number of stalled cycles before acceptance.
    task automatic send(input logic sel, input logic [15:0] data, output int waited);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 32'(waited), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        if (bus.in_ready) begin
            if (sel) qb.push_back(data);
            else     qa.push_back(data);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int wsum;
        logic [15:0] word;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 16'hDEAD;
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;

        // 1. reset held two cycles with in_valid asserted
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
        chk("rst_a_data", 32'(bus.a_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        cycles(1);

        // 2. single route to A
        send(1'b0, 16'hA5A5, w);
        chk("t2_wait", 32'(w), 32'd0);
        chk("t2_a_valid", 32'(bus.a_valid), 32'd1);
        chk("t2_a_data", 32'(bus.a_data), 32'hA5A5);
        chk("t2_b_valid", 32'(bus.b_valid), 32'd0);
        cycles(1);
        chk("t2_a_count", 32'(bus.a_count), 32'd1);
        chk("t2_a_empty", 32'(bus.a_valid), 32'd0);

        // 3. backpressure on B
        bus.b_ready = 1'b0;
        send(1'b1, 16'h1234, w);
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 16'h5678;
        @(negedge clk);
        chk("t3_stall", 32'(bus.in_ready), 32'd0);
        chk("t3_hold", 32'(bus.b_data), 32'h1234);
        @(posedge clk); #1;
        chk("t3_hold2", 32'(bus.b_data), 32'h1234);
        bus.b_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready", 32'(bus.in_ready), 32'd1);
        qb.push_back(16'h5678);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("t3_second", 32'(bus.b_data), 32'h5678);
        cycles(2);
        chk("t3_b_count", 32'(bus.b_count), 32'd2);

        // 4. stalled B does not block A
        bus.b_ready = 1'b0;
        send(1'b1, 16'h1111, w);
        send(1'b0, 16'h00FF, w);
        chk("t4_wait", 32'(w), 32'd0);
        chk("t4_a_data", 32'(bus.a_data), 32'h00FF);
        chk("t4_b_held", 32'(bus.b_data), 32'h1111);
        bus.b_ready = 1'b1;
        cycles(2);

        // 5. 256 back-to-back words to A from a fresh counter
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        wsum = 0;
        for (int i = 0; i < 256; i++) begin
            word = 16'(i * 16'h0101 + 16'h3C00);
            send(1'b0, word, w);
            wsum += w;
        end
        chk("t5_stalls", 32'(wsum), 32'd0);
        cycles(2);
        chk("t5_wrap", 32'(bus.a_count), 32'd0);
        chk("t5_q_empty", 32'(qa.size()), 32'd0);

        // 6. reset while both slots are full and stalled
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        send(1'b0, 16'hAAAA, w);
        send(1'b1, 16'hBBBB, w);
        chk("t6_a_full", 32'(bus.a_valid), 32'd1);
        chk("t6_b_full", 32'(bus.b_valid), 32'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("t6_a_valid", 32'(bus.a_valid), 32'd0);
        chk("t6_b_valid", 32'(bus.b_valid), 32'd0);
        chk("t6_a_count", 32'(bus.a_count), 32'd0);
        chk("t6_b_count", 32'(bus.b_count), 32'd0);
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        cycles(3);
        chk("t6_no_deliv_a", 32'(bus.a_count), 32'd0);
        chk("t6_no_deliv_b", 32'(bus.b_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
